// File: rtl/bit_serial_adder_ctrl.sv
// bit_serial_adder_ctrl
// Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first,
// by reusing a single full_adder cell. A start/busy/done handshake frames
// each operation. Results appear WIDTH cycles after the start edge and are
// held until the next operation completes.
//
// Ports:
//   clk    in   1      clock, all state changes on the rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only while idle
//   sub    in   1      0 = a+b+cin, 1 = a-b (cin ignored)
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in for add mode
//   busy   out  1      high while an operation is running or completing
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  result of the last completed operation
//   cout   out  1      final carry (subtract: 1 = no borrow)
//   ovf    out  1      signed overflow of the last completed operation

// Single-bit full adder cell shared across all bit positions.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module bit_serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;

   // The latched operands shift right every RUN cycle, so bit 0 is always
   // the current bit position; this avoids a variable bit-select mux.
   full_adder u_fa (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bits enter from the MSB side so that after WIDTH shifts the
   // LSB computed first has arrived at bit 0.
   always_comb begin
      shreg_next            = shreg >> 1;
      shreg_next[WIDTH-1]   = fa_sum;
      last_bit              = (cnt == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Datapath. Subtraction is a + ~b + 1, so b is inverted and the carry
   // flop is preset to 1 at acceptance. Overflow is the carry into the MSB
   // (still in the carry flop during the last bit) XOR the carry out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a  <= '0;
         op_b  <= '0;
         shreg <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  shreg <= '0;
               end
            end
            RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               carry <= fa_cout;
               shreg <= shreg_next;
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= shreg_next;
                  cout <= fa_cout;
                  ovf  <= carry ^ fa_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb_bit_serial_adder_ctrl
// Directed bench for bit_serial_adder_ctrl. One instance at WIDTH=8 and one
// at WIDTH=1. Stimulus tasks push hand-computed expected results into
// per-instance queues; monitor processes pop and compare on every done pulse.
module tb_bit_serial_adder_ctrl;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic       clk;

   logic       rst8, start8, sub8, cin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   logic       rst1, start1, sub1, cin1;
   logic [0:0] a1, b1;
   logic       busy1, done1, cout1, ovf1;
   logic [0:0] sum1;

   exp_t       q8[$];
   exp_t       q1[$];
   exp_t       mon_e8;
   exp_t       mon_e1;

   int         checks      = 0;
   int         errors      = 0;
   int         done_count8 = 0;
   int         done_count1 = 0;
   logic [7:0] last_sum8;

   bit_serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst8),
      .start (start8),
      .sub   (sub8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8),
      .ovf   (ovf8)
   );

   bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst1),
      .start (start1),
      .sub   (sub1),
      .a     (a1),
      .b     (b1),
      .cin   (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1),
      .ovf   (ovf1)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor for the 8-bit instance: every done pulse consumes one entry.
   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         done_count8++;
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done8: got done with sum %0h, expected no done", sum8);
         end else begin
            mon_e8 = q8.pop_front();
            checkOutput("sum8", 64'(sum8), mon_e8.sum);
            checkOutput("cout8", 64'(cout8), 64'(mon_e8.cout));
            checkOutput("ovf8", 64'(ovf8), 64'(mon_e8.ovf));
         end
      end
   end

   // Monitor for the 1-bit instance.
   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         done_count1++;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done1: got done with sum %0h, expected no done", sum1);
         end else begin
            mon_e1 = q1.pop_front();
            checkOutput("sum1", 64'(sum1), mon_e1.sum);
            checkOutput("cout1", 64'(cout1), 64'(mon_e1.cout));
            checkOutput("ovf1", 64'(ovf1), 64'(mon_e1.ovf));
         end
      end
   end

   // Issue one 8-bit operation, check busy and held outputs during RUN,
   // check latency of the done pulse and the return to idle.
   task automatic applyStimulus(input logic s, input logic [7:0] av, input logic [7:0] bv,
                                input logic c, input logic [7:0] es, input logic ec,
                                input logic eo);
      exp_t e;
      int   n;
      sub8   = s;
      a8     = av;
      b8     = bv;
      cin8   = c;
      start8 = 1'b1;
      e.sum  = 64'(es);
      e.cout = ec;
      e.ovf  = eo;
      q8.push_back(e);
      @(posedge clk);
      #1;
      start8 = 1'b0;
      sub8   = ~s;
      a8     = ~av;
      b8     = ~bv;
      cin8   = ~c;
      n      = 0;
      while (done8 !== 1'b1 && n < 20) begin
         checkOutput("busy_run8", 64'(busy8), 64'd1);
         checkOutput("hold_sum8", 64'(sum8), 64'(last_sum8));
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("latency8", 64'(n), 64'd8);
      last_sum8 = es;
      @(posedge clk);
      #1;
      checkOutput("idle_busy8", 64'(busy8), 64'd0);
      checkOutput("idle_done8", 64'(done8), 64'd0);
   endtask

   // Issue one 1-bit operation and check the single-cycle latency.
   task automatic applyStimulus1(input logic s, input logic av, input logic bv,
                                 input logic c, input logic es, input logic ec,
                                 input logic eo);
      exp_t e;
      int   n;
      sub1   = s;
      a1     = av;
      b1     = bv;
      cin1   = c;
      start1 = 1'b1;
      e.sum  = 64'(es);
      e.cout = ec;
      e.ovf  = eo;
      q1.push_back(e);
      @(posedge clk);
      #1;
      start1 = 1'b0;
      n      = 0;
      while (done1 !== 1'b1 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("latency1", 64'(n), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("idle_busy1", 64'(busy1), 64'd0);
   endtask

   // Back-to-back table for WIDTH=1: {sub, a, b, cin, sum, cout, ovf}.
   logic [6:0] vec1 [5];
   int         base;

   initial begin
      vec1[0] = 7'b0_1_1_1_1_1_0;
      vec1[1] = 7'b0_1_0_0_1_0_0;
      vec1[2] = 7'b0_1_1_0_0_1_1;
      vec1[3] = 7'b1_0_1_0_1_0_1;
      vec1[4] = 7'b1_1_1_1_0_1_0;

      rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
      rst1 = 1'b1; start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
      last_sum8 = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst8 = 1'b0;
      rst1 = 1'b0;
      checkOutput("rst_busy8", 64'(busy8), 64'd0);
      checkOutput("rst_done8", 64'(done8), 64'd0);
      checkOutput("rst_sum8", 64'(sum8), 64'd0);
      checkOutput("rst_cout8", 64'(cout8), 64'd0);
      checkOutput("rst_ovf8", 64'(ovf8), 64'd0);
      checkOutput("rst_busy1", 64'(busy1), 64'd0);
      checkOutput("rst_sum1", 64'(sum1), 64'd0);

      $display("[TB] add and sub vectors, WIDTH=8");
      applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h20, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

      $display("[TB] reset in the middle of RUN");
      base   = done_count8;
      sub8   = 1'b0;
      a8     = 8'h77;
      b8     = 8'h11;
      cin8   = 1'b0;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst8 = 1'b1;
      @(posedge clk);
      #1;
      rst8 = 1'b0;
      checkOutput("abort_busy8", 64'(busy8), 64'd0);
      checkOutput("abort_done8", 64'(done8), 64'd0);
      checkOutput("abort_sum8", 64'(sum8), 64'd0);
      checkOutput("abort_cout8", 64'(cout8), 64'd0);
      checkOutput("abort_ovf8", 64'(ovf8), 64'd0);
      last_sum8 = 8'h00;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("abort_no_done8", 64'(done_count8 - base), 64'd0);
      applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

      $display("[TB] reset and start at the same edge");
      rst8   = 1'b1;
      start8 = 1'b1;
      a8     = 8'h01;
      b8     = 8'h01;
      @(posedge clk);
      #1;
      rst8   = 1'b0;
      start8 = 1'b0;
      checkOutput("rst_start_busy8", 64'(busy8), 64'd0);
      last_sum8 = 8'h00;
      base = done_count8;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("rst_start_no_done8", 64'(done_count8 - base), 64'd0);

      $display("[TB] start while busy is ignored");
      base   = done_count8;
      sub8   = 1'b0;
      a8     = 8'h12;
      b8     = 8'h34;
      cin8   = 1'b0;
      start8 = 1'b1;
      begin
         exp_t e;
         e.sum  = 64'h46;
         e.cout = 1'b0;
         e.ovf  = 1'b0;
         q8.push_back(e);
      end
      @(posedge clk);
      #1;
      start8 = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         if (k == 3 || k == 9) begin
            start8 = 1'b1;
            sub8   = 1'b1;
            a8     = 8'hFF;
            b8     = 8'hEE;
            cin8   = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start8 = 1'b0;
      checkOutput("overlap_one_done8", 64'(done_count8 - base), 64'd1);
      checkOutput("overlap_idle8", 64'(busy8), 64'd0);
      checkOutput("overlap_sum_held8", 64'(sum8), 64'h46);
      last_sum8 = 8'h46;

      $display("[TB] WIDTH=1 single and back-to-back operations");
      applyStimulus1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      base   = done_count1;
      start1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         logic [6:0] v;
         v      = vec1[i];
         sub1   = v[6];
         a1     = v[5];
         b1     = v[4];
         cin1   = v[3];
         e.sum  = 64'(v[2]);
         e.cout = v[1];
         e.ovf  = v[0];
         q1.push_back(e);
         @(posedge clk);
         #1;
         checkOutput("b2b_busy1", 64'(busy1), 64'd1);
         checkOutput("b2b_run_done1", 64'(done1), 64'd0);
         @(posedge clk);
         #1;
         checkOutput("b2b_done1", 64'(done1), 64'd1);
         if (i == 4) start1 = 1'b0;
         @(posedge clk);
         #1;
         checkOutput("b2b_idle1", 64'(busy1), 64'd0);
      end
      start1 = 1'b0;
      checkOutput("b2b_count1", 64'(done_count1 - base), 64'd5);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("q8_drained", 64'(q8.size()), 64'd0);
      checkOutput("q1_drained", 64'(q1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so a stuck design cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
